myproject_mul_arb: RTL and testbench
====================================

# myproject_mul_arb

Round-robin arbiter and sequencer that shares one external 32s x 18s -> 48 combinational signed multiplier among N_REQ requesters inside the HLS-generated VAE datapath. Each requester presents an operand pair and tag with a valid/ready handshake. The block registers the granted operands in front of the multiplier and registers the product behind it. It then returns the result, requester index and tag on a single backpressured response channel, sustaining one product per cycle.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DIN0_WIDTH, 32, signed operand 0 width
- DIN1_WIDTH, 18, signed operand 1 width
- DOUT_WIDTH, 48, product width as delivered by the multiplier
- TAG_WIDTH, 4, opaque per-request tag width
- ID_WIDTH, 2, width of requester index (>= clog2(N_REQ))

Ports:
- ap_clk  in  1  single clock, rising edge
- ap_rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, at most one bit high
- req_din0  in  N_REQ*DIN0_WIDTH  operand 0, requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH]
- req_din1  in  N_REQ*DIN1_WIDTH  operand 1, packed the same way
- req_tag  in  N_REQ*TAG_WIDTH  tag, packed the same way
- mul_din0  out  DIN0_WIDTH  to multiplier din0
- mul_din1  out  DIN1_WIDTH  to multiplier din1
- mul_dout  in  DOUT_WIDTH  from multiplier dout, same cycle
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_dout  out  DOUT_WIDTH  product
- rsp_id  out  ID_WIDTH  index of the originating requester
- rsp_tag  out  TAG_WIDTH  tag of the originating request
- busy  out  1  any pipeline stage occupied

## Operation
- Pipeline stages:
  - S1 is the operand register: v1, din0, din1, id, tag.
  - S2 is the result register: v2, dout, id, tag.
  - rsp_* is driven from S2.
  - Stage occupancy (v1, v2) is the state: EMPTY (0,0), FILL (1,0), DRAIN (0,1), FULL (1,1).
- Advance conditions:
  - adv2 = !v2 | rsp_ready.
  - adv1 = !v1 | adv2.
- Arbitration:
  - When adv1 is true, grant the first requester with req_valid set, searching from ptr+1 (mod N_REQ) upward.
  - req_ready is the one-hot grant and is 0 when adv1 is false.
  - req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
  - On a grant, ptr becomes the granted index. If no request is valid, ptr holds.
- Accept: when req_valid[i] & req_ready[i], S1 loads requester i's operands, id = i and tag, and v1 = 1. Otherwise, if adv1, v1 = 0.
- mul_din0/mul_din1 are driven from S1 at all times. When v1 = 0 they hold their last value, which keeps multiplier inputs stable.
- When adv2 & v1, S2 loads dout = mul_dout together with S1's id/tag, and v2 = 1. When adv2 & !v1, v2 = 0.
- Arithmetic: the block does not modify the product. rsp_dout is the multiplier's DOUT_WIDTH result, i.e. the low 48 bits of the two's-complement product, with no saturation.
- Stall: rsp_valid = 1 and rsp_ready = 0 freezes S2. If v1 is also set, S1 freezes and all req_ready bits drop to 0. Response payload is stable while rsp_valid is high and rsp_ready is low.
- Responses are returned in acceptance order; no reordering.
- busy = v1 | v2.

## Timing
- Reset (ap_rst high, asynchronous) clears and holds the following until release:
  - v1, v2, rsp_valid, req_ready and busy are 0.
  - rsp_dout, rsp_id, rsp_tag, mul_din0 and mul_din1 are 0.
  - ptr = N_REQ-1, so requester 0 wins first.
- Reset mid-operation discards in-flight requests; no response is produced for them.
- Latency: a request accepted at edge E0 gives rsp_valid = 1 after edge E1, i.e. 2 cycles. With OUTREG it is 3 cycles.
- Throughput: 1 accept per cycle while rsp_ready = 1.
- Simultaneous events:
  - In FULL with rsp_ready = 1, S2 retires, S1 moves to S2 and a new request is accepted, all on the same edge.
  - A request held while its req_ready = 0 must keep its payload stable; it is granted when its turn comes.
- Fairness: with all N_REQ requesting continuously, each is granted exactly once per N_REQ accepts.

## Configuration
- MYPROJECT_MUL_ARB_OUTREG_EN:
  - Defined: adds S3 between S2 and rsp_*, a register with the same adv rule (v3, dout, id, tag). Latency becomes 3 cycles, throughput and ordering are unchanged, S3 resets to 0, and busy = v1|v2|v3.
  - Undefined: the two-stage pipeline and 2-cycle latency described above.

## Test plan
- Reset: assert ap_rst mid-stream with 2 requests in flight -> all outputs 0 immediately; after release, no stale response appears; first grant goes to requester 0.
- Single request: requester 2 sends din0 = 0x7FFFFFFF, din1 = -2 (0x3FFFE), tag = 5, with rsp_ready = 1 -> exactly 2 cycles later rsp_valid = 1, rsp_dout = 0xFFFF00000002, rsp_id = 2, rsp_tag = 5.
- Round-robin: all 4 valid continuously with rsp_ready = 1 -> grant order 0,1,2,3,0,1…; one response per cycle; ids match grant order.
- Backpressure: rsp_ready = 0 for 5 cycles with requests pending -> S1 and S2 fill, req_ready goes all 0, rsp payload is stable; on release, results drain in order with no loss or duplicate.
- Sparse requests: only requesters 1 and 3 valid, ptr = 1 -> grant goes to 3, then 1; idle cycles leave ptr unchanged.
- OUTREG build: repeat the single-request case -> response appears after 3 cycles with identical values.

Source files
------------

// File: rtl/myproject_mul_arb.sv
// myproject_mul_arb: round-robin sharing of one external signed multiplier among N_REQ requesters; optional MYPROJECT_MUL_ARB_OUTREG_EN adds an output register.
// Latency: accept edge to rsp_valid is 2 cycles (3 with the output register); one product per cycle sustained.
// Backpressure: rsp_ready low freezes occupied stages; every req_ready bit drops once the operand stage cannot move.
module myproject_mul_arb #(
  parameter int N_REQ      = 4,
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 18,
  parameter int DOUT_WIDTH = 48,
  parameter int TAG_WIDTH  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*DIN0_WIDTH-1:0]     req_din0,
  input  logic [N_REQ*DIN1_WIDTH-1:0]     req_din1,
  input  logic [N_REQ*TAG_WIDTH-1:0]      req_tag,
  output logic [DIN0_WIDTH-1:0]           mul_din0,
  output logic [DIN1_WIDTH-1:0]           mul_din1,
  input  logic [DOUT_WIDTH-1:0]           mul_dout,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DOUT_WIDTH-1:0]           rsp_dout,
  output logic [ID_WIDTH-1:0]             rsp_id,
  output logic [TAG_WIDTH-1:0]            rsp_tag,
  output logic                            busy
);

  // Stage occupancy {v1,v2}: EMPTY 00, FILL 10, DRAIN 01, FULL 11.
  logic                  v1, v2;
  logic [DIN0_WIDTH-1:0] s1_din0;
  logic [DIN1_WIDTH-1:0] s1_din1;
  logic [ID_WIDTH-1:0]   s1_id, s2_id;
  logic [TAG_WIDTH-1:0]  s1_tag, s2_tag;
  logic [DOUT_WIDTH-1:0] s2_dout;
  logic [ID_WIDTH-1:0]   ptr, gnt_id;
  logic [N_REQ-1:0]      gnt;
  logic                  gnt_any;
  logic                  adv1, adv2, s2_rdy;

  assign adv2 = !v2 | s2_rdy;
  assign adv1 = !v1 | adv2;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = ptr;
    gnt_any = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_WIDTH'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

  assign req_ready = (adv1 && !ap_rst) ? gnt : '0;
  assign mul_din0  = s1_din0;
  assign mul_din1  = s1_din1;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr     <= ID_WIDTH'(N_REQ - 1);
      v1      <= 1'b0;
      s1_din0 <= '0;
      s1_din1 <= '0;
      s1_id   <= '0;
      s1_tag  <= '0;
      v2      <= 1'b0;
      s2_dout <= '0;
      s2_id   <= '0;
      s2_tag  <= '0;
    end else begin
      if (adv1) begin
        v1 <= gnt_any;
        // Operands only change on an accept, keeping the multiplier inputs quiet when idle.
        if (gnt_any) begin
          ptr     <= gnt_id;
          s1_din0 <= req_din0[gnt_id*DIN0_WIDTH +: DIN0_WIDTH];
          s1_din1 <= req_din1[gnt_id*DIN1_WIDTH +: DIN1_WIDTH];
          s1_tag  <= req_tag[gnt_id*TAG_WIDTH +: TAG_WIDTH];
          s1_id   <= gnt_id;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s2_dout <= mul_dout;
          s2_id   <= s1_id;
          s2_tag  <= s1_tag;
        end
      end
    end
  end

`ifdef MYPROJECT_MUL_ARB_OUTREG_EN
  logic                  v3;
  logic [DOUT_WIDTH-1:0] s3_dout;
  logic [ID_WIDTH-1:0]   s3_id;
  logic [TAG_WIDTH-1:0]  s3_tag;

  assign s2_rdy = !v3 | rsp_ready;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v3      <= 1'b0;
      s3_dout <= '0;
      s3_id   <= '0;
      s3_tag  <= '0;
    end else if (s2_rdy) begin
      v3 <= v2;
      if (v2) begin
        s3_dout <= s2_dout;
        s3_id   <= s2_id;
        s3_tag  <= s2_tag;
      end
    end
  end

  assign rsp_valid = v3;
  assign rsp_dout  = s3_dout;
  assign rsp_id    = s3_id;
  assign rsp_tag   = s3_tag;
  assign busy      = v1 | v2 | v3;
`else
  assign s2_rdy    = rsp_ready;
  assign rsp_valid = v2;
  assign rsp_dout  = s2_dout;
  assign rsp_id    = s2_id;
  assign rsp_tag   = s2_tag;
  assign busy      = v1 | v2;
`endif

endmodule

// File: tb/tb_myproject_mul_arb.sv
// Bench for myproject_mul_arb: external multiplier model, response scoreboard, per-scenario tasks.
module tb_myproject_mul_arb;
  localparam int N  = 4;
  localparam int W0 = 32;
  localparam int W1 = 18;
  localparam int WD = 48;
  localparam int WT = 4;
  localparam int WI = 2;
`ifdef MYPROJECT_MUL_ARB_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              ap_clk, ap_rst;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*W0-1:0]   req_din0;
  logic [N*W1-1:0]   req_din1;
  logic [N*WT-1:0]   req_tag;
  logic [W0-1:0]     mul_din0;
  logic [W1-1:0]     mul_din1;
  logic [WD-1:0]     mul_dout;
  logic              rsp_valid, rsp_ready, busy;
  logic [WD-1:0]     rsp_dout;
  logic [WI-1:0]     rsp_id;
  logic [WT-1:0]     rsp_tag;

  logic [W0-1:0] d0 [N];
  logic [W1-1:0] d1 [N];
  logic [WT-1:0] tg [N];

  typedef struct packed {
    logic [WD-1:0] dout;
    logic [WI-1:0] id;
    logic [WT-1:0] tag;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_chk, n_pass, last_gnt;

  myproject_mul_arb #(.N_REQ(N), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WD),
                      .TAG_WIDTH(WT), .ID_WIDTH(WI)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1), .req_tag(req_tag),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .busy(busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // External combinational 32s x 18s multiplier, low 48 bits.
  logic signed [WD-1:0] ext0, ext1;
  assign ext0     = {{(WD-W0){mul_din0[W0-1]}}, mul_din0};
  assign ext1     = {{(WD-W1){mul_din1[W1-1]}}, mul_din1};
  assign mul_dout = ext0 * ext1;

  always_comb begin
    req_din0 = '0;
    req_din1 = '0;
    req_tag  = '0;
    for (int i = 0; i < N; i++) begin
      req_din0[i*W0 +: W0] = d0[i];
      req_din1[i*W1 +: W1] = d1[i];
      req_tag[i*WT +: WT]  = tg[i];
    end
  end

  function automatic logic [WD-1:0] exp_prod(input logic [W0-1:0] a, input logic [W1-1:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    return p[WD-1:0];
  endfunction

  // Scoreboard: push on accept, pop and compare on response retire.
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_rsp: got id=%0d tag=%0d dout=%h, required no response", rsp_id, rsp_tag, rsp_dout);
        end else begin
          e_mon = q.pop_front();
          if ({rsp_dout, rsp_id, rsp_tag} !== e_mon)
            $display("FAIL rsp_payload: got dout=%h id=%0d tag=%0d, required dout=%h id=%0d tag=%0d",
                     rsp_dout, rsp_id, rsp_tag, e_mon.dout, e_mon.id, e_mon.tag);
          else n_pass++;
        end
      end
      n_chk++;
      if (!$onehot0(req_ready)) $display("FAIL ready_onehot: got %b, required at most one bit", req_ready);
      else n_pass++;
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) q.push_back({exp_prod(d0[i], d1[i]), WI'(i), tg[i]});
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drain();
    int c = 0;
    rsp_ready = 1'b1;
    req_valid = '0;
    while ((q.size() != 0 || busy) && c < 50) begin
      tick();
      c++;
    end
    n_chk++;
    if (q.size() != 0 || busy) $display("FAIL drain: got %0d outstanding busy=%b, required 0 outstanding", q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic seen;
    req_valid = '1;
    #2;
    n_chk++;
    if ({rsp_valid, busy, req_ready, mul_din0, mul_din1} !== '0)
      $display("FAIL reset_state: got rsp_valid=%b busy=%b req_ready=%b din0=%h din1=%h, required all 0",
               rsp_valid, busy, req_ready, mul_din0, mul_din1);
    else n_pass++;
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    n_chk++;
    if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b, required 0001", req_ready);
    else n_pass++;
    tick();
    @(negedge ap_clk);
    n_chk++;
    if (req_ready !== 4'b0010) $display("FAIL reset_second_grant: got %b, required 0010", req_ready);
    else n_pass++;
    tick();
    rsp_ready = 1'b0;
    n_chk++;
    if (q.size() != 2 || busy !== 1'b1) $display("FAIL inflight: got %0d busy=%b, required 2 busy=1", q.size(), busy);
    else n_pass++;
    #2 ap_rst = 1'b1;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_dout, rsp_id, rsp_tag, busy, req_ready, mul_din0, mul_din1} !== '0)
      $display("FAIL reset_midstream: got rsp_valid=%b dout=%h id=%0d tag=%0d busy=%b ready=%b din0=%h din1=%h, required all 0",
               rsp_valid, rsp_dout, rsp_id, rsp_tag, busy, req_ready, mul_din0, mul_din1);
    else n_pass++;
    @(negedge ap_clk);
    tick();
    ap_rst    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    seen      = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL stale_rsp: got rsp_valid after reset, required none");
    else n_pass++;
    req_valid = '1;
    @(negedge ap_clk);
    n_chk++;
    if (req_ready !== 4'b0001) $display("FAIL post_reset_grant: got %b, required 0001", req_ready);
    else n_pass++;
    tick();
    last_gnt = 0;
    drain();
  endtask

  task automatic test_single();
    int  lat = 0;
    logic got = 1'b0;
    tick();
    d0[2] = 32'h7FFF_FFFF;
    d1[2] = 18'h3FFFE;
    tg[2] = 4'd5;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    n_chk++;
    if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b, required 0100", req_ready);
    else n_pass++;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      req_valid = '0;
      lat++;
      @(negedge ap_clk);
      if (rsp_valid) got = 1'b1;
    end
    n_chk++;
    if (!got || lat != LAT) $display("FAIL single_latency: got %0d (seen=%b), required %0d", lat, got, LAT);
    else n_pass++;
    n_chk++;
    if ({rsp_dout, rsp_id, rsp_tag} !== {48'hFFFF_0000_0002, 2'd2, 4'd5})
      $display("FAIL single_value: got dout=%h id=%0d tag=%0d, required dout=ffff00000002 id=2 tag=5",
               rsp_dout, rsp_id, rsp_tag);
    else n_pass++;
    last_gnt = 2;
    drain();
  endtask

  task automatic test_round_robin();
    int ex, g, nrsp;
    nrsp = 0;
    for (int i = 0; i < N; i++) begin
      d0[i] = $urandom;
      d1[i] = W1'($urandom);
      tg[i] = WT'($urandom);
    end
    tick();
    req_valid = '1;
    rsp_ready = 1'b1;
    ex = (last_gnt + 1) % N;
    for (int k = 0; k < 12; k++) begin
      @(negedge ap_clk);
      n_chk++;
      if (req_ready !== N'(1 << ex)) $display("FAIL rr_grant%0d: got %b, required %b", k, req_ready, N'(1 << ex));
      else n_pass++;
      if (rsp_valid) nrsp++;
      g  = ex;
      ex = (ex + 1) % N;
      tick();
      d0[g] = $urandom;
      d1[g] = W1'($urandom);
      tg[g] = WT'($urandom);
    end
    req_valid = '0;
    n_chk++;
    if (nrsp != 12 - LAT) $display("FAIL rr_throughput: got %0d responses, required %0d", nrsp, 12 - LAT);
    else n_pass++;
    last_gnt = g;
    drain();
  endtask

  task automatic test_backpressure();
    int ex, g;
    g = last_gnt;
    tick();
    req_valid = '1;
    rsp_ready = 1'b0;
    ex = (last_gnt + 1) % N;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge ap_clk);
      if (k < LAT) begin
        n_chk++;
        if (req_ready !== N'(1 << ex)) $display("FAIL bp_fill%0d: got %b, required %b", k, req_ready, N'(1 << ex));
        else n_pass++;
        g  = ex;
        ex = (ex + 1) % N;
        tick();
        d0[g] = $urandom;
        d1[g] = W1'($urandom);
        tg[g] = WT'($urandom);
      end else begin
        n_chk++;
        if (req_ready !== '0 || rsp_valid !== 1'b1)
          $display("FAIL bp_stall%0d: got ready=%b rsp_valid=%b, required 0000 and 1", k, req_ready, rsp_valid);
        else n_pass++;
        n_chk++;
        if (q.size() == 0 || {rsp_dout, rsp_id, rsp_tag} !== q[0])
          $display("FAIL bp_hold%0d: got dout=%h id=%0d tag=%0d, required oldest accepted request", k, rsp_dout, rsp_id, rsp_tag);
        else n_pass++;
        tick();
      end
    end
    last_gnt = g;
    drain();
  endtask

  task automatic test_sparse();
    int exp_g [3] = '{3, 1, 3};
    tick();
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    n_chk++;
    if (req_ready !== 4'b0010) $display("FAIL sparse_setup: got %b, required 0010", req_ready);
    else n_pass++;
    tick();
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      n_chk++;
      if (req_ready !== N'(1 << exp_g[k])) $display("FAIL sparse_grant%0d: got %b, required %b", k, req_ready, N'(1 << exp_g[k]));
      else n_pass++;
      tick();
      d0[exp_g[k]] = $urandom;
      tg[exp_g[k]] = WT'($urandom);
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      n_chk++;
      if (req_ready !== '0) $display("FAIL sparse_idle%0d: got %b, required 0000", k, req_ready);
      else n_pass++;
      tick();
    end
    req_valid = 4'b1010;
    @(negedge ap_clk);
    n_chk++;
    if (req_ready !== 4'b0010) $display("FAIL sparse_ptr_hold: got %b, required 0010", req_ready);
    else n_pass++;
    tick();
    last_gnt = 1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    last_gnt  = N - 1;
    ap_rst    = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      d0[i] = W0'(32'h1000 + i);
      d1[i] = W1'(i + 3);
      tg[i] = WT'(i + 8);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sparse();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
